trigger_capture: RTL



---
 rtl/scope_pkg.sv | 20 ++
 rtl/capture_ram.sv | 28 ++
 rtl/trigger_capture.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/scope_pkg.sv
// Shared definitions for the oscilloscope acquisition path: FSM encoding,
// sample width and ADC full-scale limit.
package scope_pkg;

   typedef enum logic [1:0] {
      S_ARM     = 2'd0,
      S_CAPTURE = 2'd1,
      S_PLAY    = 2'd2,
      S_HOLD    = 2'd3
   } state_e;

   localparam int VAL_RES = 16;
   localparam int ADC_MAX = 4095;

   // Pointer width for a buffer of the given depth (never narrower than 1 bit).
   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/capture_ram.sv
// DEPTH x W simple dual-port RAM: one write port, one registered read port.
module capture_ram
   import scope_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int W     = 16,
   localparam int AW   = ptr_w(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/trigger_capture.sv
// Decimate ADC samples, wait for a level-crossing (or forced) trigger,
// capture DEPTH samples and replay them as a val/readValEn burst.
module trigger_capture #(
   parameter int VAL_RES      = scope_pkg::VAL_RES,
   parameter int DEPTH        = 8,
   parameter int AUTO_TIMEOUT = 1000000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [VAL_RES-1:0] adcVal,
   input  logic               adcValid,
   input  logic [VAL_RES-1:0] trigLevel,
   input  logic               trigEdge,
   input  logic               autoMode,
   input  logic [7:0]         decim,
   input  logic               frameReq,
   output logic [VAL_RES-1:0] val,
   output logic               readValEn,
   output logic               frameDone,
   output logic               triggered,
   output logic [1:0]         state
);
   import scope_pkg::*;

   localparam int AW = ptr_w(DEPTH);
   localparam int TW = (AUTO_TIMEOUT > 1) ? $clog2(AUTO_TIMEOUT) : 1;
   localparam logic [VAL_RES-1:0] MAX_V = VAL_RES'(ADC_MAX);

   state_e             state_q, state_d;
   logic               arm_entry_q, arm_entry_d;
   logic [VAL_RES-1:0] level_q, level_d;
   logic               edge_q, edge_d;
   logic [7:0]         decim_q, decim_d;
   logic [7:0]         dec_cnt_q, dec_cnt_d;
   logic [VAL_RES-1:0] prev_q, prev_d;
   logic               prev_valid_q, prev_valid_d;
   logic [TW-1:0]      to_cnt_q, to_cnt_d;
   logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
   logic               rd_vld_q, rd_vld_d;
   logic               rd_last_q, rd_last_d;
   logic               read_val_en_q, read_val_en_d;
   logic               last_q, last_d;
   logic               frame_done_q, frame_done_d;
   logic [VAL_RES-1:0] val_q, val_d;
   logic               triggered_q, triggered_d;

   logic               we, re;
   logic [AW-1:0]      waddr;
   logic [VAL_RES-1:0] rd_data, cur;
   logic [VAL_RES-1:0] level_eff;
   logic               edge_eff;
   logic [7:0]         decim_eff;
   logic               capturing, accept, hit, to_sat;

   // The first cycle in S_ARM uses the live config while it is being latched.
   assign level_eff = arm_entry_q ? trigLevel : level_q;
   assign edge_eff  = arm_entry_q ? trigEdge  : edge_q;
   assign decim_eff = arm_entry_q ? decim     : decim_q;

   assign cur       = (adcVal > MAX_V) ? MAX_V : adcVal;
   assign capturing = (state_q == S_ARM) || (state_q == S_CAPTURE);
   assign accept    = capturing && adcValid && (dec_cnt_q == 8'd0);
   assign hit       = prev_valid_q && (edge_eff ? (prev_q > level_eff && cur <= level_eff)
                                                : (prev_q < level_eff && cur >= level_eff));
   assign to_sat    = (to_cnt_q == TW'(AUTO_TIMEOUT - 1));

   always_comb begin
      state_d       = state_q;
      arm_entry_d   = arm_entry_q;
      level_d       = level_q;
      edge_d        = edge_q;
      decim_d       = decim_q;
      dec_cnt_d     = dec_cnt_q;
      prev_d        = prev_q;
      prev_valid_d  = prev_valid_q;
      to_cnt_d      = to_cnt_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      triggered_d   = triggered_q;
      we            = 1'b0;
      waddr         = wr_ptr_q;
      re            = 1'b0;

      if (arm_entry_q) begin
         level_d     = trigLevel;
         edge_d      = trigEdge;
         decim_d     = decim;
         arm_entry_d = 1'b0;
      end

      if (capturing && adcValid)
         dec_cnt_d = (dec_cnt_q == decim_eff) ? 8'd0 : dec_cnt_q + 8'd1;

      case (state_q)
         S_ARM: begin
            if (!to_sat) to_cnt_d = to_cnt_q + TW'(1);
            if (accept) begin
               prev_d       = cur;
               prev_valid_d = 1'b1;
               if (hit || (autoMode && to_sat)) begin
                  we          = 1'b1;
                  waddr       = '0;
                  wr_ptr_d    = AW'(1);
                  triggered_d = hit;
                  state_d     = S_CAPTURE;
               end
            end
         end
         S_CAPTURE: begin
            if (accept) begin
               we = 1'b1;
               if (wr_ptr_q == AW'(DEPTH - 1)) begin
                  rd_ptr_d = '0;
                  state_d  = S_PLAY;
               end else begin
                  wr_ptr_d = wr_ptr_q + AW'(1);
               end
            end
         end
         S_PLAY: begin
            re       = 1'b1;
            rd_ptr_d = rd_ptr_q + AW'(1);
            if (rd_ptr_q == AW'(DEPTH - 1)) state_d = S_HOLD;
         end
         default: begin
            if (frameReq) begin
               state_d      = S_ARM;
               arm_entry_d  = 1'b1;
               dec_cnt_d    = 8'd0;
               to_cnt_d     = '0;
               prev_valid_d = 1'b0;
            end
         end
      endcase
   end

   // Read pipeline: issue -> RAM register -> output register -> frameDone.
   always_comb begin
      rd_vld_d      = re;
      rd_last_d     = re && (rd_ptr_q == AW'(DEPTH - 1));
      read_val_en_d = rd_vld_q;
      last_d        = rd_last_q;
      frame_done_d  = last_q;
      val_d         = rd_vld_q ? rd_data : val_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_ARM;
         arm_entry_q   <= 1'b1;
         level_q       <= '0;
         edge_q        <= 1'b0;
         decim_q       <= 8'd0;
         dec_cnt_q     <= 8'd0;
         prev_q        <= '0;
         prev_valid_q  <= 1'b0;
         to_cnt_q      <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         rd_vld_q      <= 1'b0;
         rd_last_q     <= 1'b0;
         read_val_en_q <= 1'b0;
         last_q        <= 1'b0;
         frame_done_q  <= 1'b0;
         val_q         <= '0;
         triggered_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         arm_entry_q   <= arm_entry_d;
         level_q       <= level_d;
         edge_q        <= edge_d;
         decim_q       <= decim_d;
         dec_cnt_q     <= dec_cnt_d;
         prev_q        <= prev_d;
         prev_valid_q  <= prev_valid_d;
         to_cnt_q      <= to_cnt_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         rd_vld_q      <= rd_vld_d;
         rd_last_q     <= rd_last_d;
         read_val_en_q <= read_val_en_d;
         last_q        <= last_d;
         frame_done_q  <= frame_done_d;
         val_q         <= val_d;
         triggered_q   <= triggered_d;
      end
   end

   capture_ram #(.DEPTH(DEPTH), .W(VAL_RES)) u_ram (
      .clk   (clk),
      .we    (we),
      .waddr (waddr),
      .wdata (cur),
      .re    (re),
      .raddr (rd_ptr_q),
      .rdata (rd_data)
   );

   assign val       = val_q;
   assign readValEn = read_val_en_q;
   assign frameDone = frame_done_q;
   assign triggered = triggered_q;
   assign state     = state_q;

endmodule
